// File: rtl/local_port_arbiter.sv
// Round-robin arbiter sharing one router local input port among NUM_REQ packet
// sources, with bounded bursts per grant and a single registered output slot.
module local_port_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BURST_LEN = 4,
  parameter int PTR_W     = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [NUM_REQ*32-1:0]   req_packet,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             out_packet,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [PTR_W-1:0]        gnt_id,
  output logic                    busy,
  output logic [31:0]             pkt_count
);

  localparam logic [PTR_W-1:0] LAST_IDX   = PTR_W'(NUM_REQ - 1);
  localparam logic [4:0]       BURST_LAST = 5'(BURST_LEN - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg, state_next;
  logic [PTR_W-1:0] rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0] gnt_id_reg, gnt_id_next;
  logic [4:0]       burst_cnt_reg, burst_cnt_next;
  logic [31:0]      out_packet_reg, out_packet_next;
  logic             out_valid_reg, out_valid_next;
  logic [31:0]      pkt_count_reg, pkt_count_next;

  logic [31:0]      pkt_arr [NUM_REQ];
  logic             slot_free;
  logic             grant_ready;
  logic             xfer;
  logic             release_grant;
  logic [PTR_W-1:0] gnt_succ;

  logic             hi_found, lo_found;
  logic [PTR_W-1:0] hi_idx, lo_idx, pick_idx;

  assign slot_free   = !out_valid_reg || out_ready;
  assign grant_ready = (state_reg == GRANT) && en && slot_free;
  assign xfer        = grant_ready && req_valid[gnt_id_reg];
  assign gnt_succ    = (gnt_id_reg == LAST_IDX) ? '0 : gnt_id_reg + PTR_W'(1);
  assign release_grant = (xfer && (burst_cnt_reg == BURST_LAST)) ||
                         !req_valid[gnt_id_reg] || !en;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign pkt_arr[gi]   = req_packet[32*gi +: 32];
      assign req_ready[gi] = grant_ready && (gnt_id_reg == PTR_W'(gi));
    end
  endgenerate

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid overall.
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        lo_found = 1'b1;
        lo_idx   = PTR_W'(k);
        if (PTR_W'(k) >= rr_ptr_reg) begin
          hi_found = 1'b1;
          hi_idx   = PTR_W'(k);
        end
      end
    end
    pick_idx = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    gnt_id_next     = gnt_id_reg;
    burst_cnt_next  = burst_cnt_reg;
    out_packet_next = out_packet_reg;
    out_valid_next  = out_valid_reg;
    pkt_count_next  = pkt_count_reg;

    case (state_reg)
      IDLE: begin
        if (en && lo_found) begin
          gnt_id_next    = pick_idx;
          burst_cnt_next = '0;
          state_next     = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          burst_cnt_next = burst_cnt_reg + 5'd1;
        end
        if (release_grant) begin
          state_next  = IDLE;
          rr_ptr_next = gnt_succ;
        end
      end
      default: state_next = IDLE;
    endcase

    // A fill in the same cycle as a drain keeps the slot occupied with new data.
    if (xfer) begin
      out_packet_next = pkt_arr[gnt_id_reg];
      out_valid_next  = 1'b1;
    end else if (out_valid_reg && out_ready) begin
      out_valid_next = 1'b0;
    end

    if (out_valid_reg && out_ready) begin
      pkt_count_next = pkt_count_reg + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      gnt_id_reg     <= '0;
      burst_cnt_reg  <= '0;
      out_packet_reg <= '0;
      out_valid_reg  <= 1'b0;
      pkt_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      gnt_id_reg     <= gnt_id_next;
      burst_cnt_reg  <= burst_cnt_next;
      out_packet_reg <= out_packet_next;
      out_valid_reg  <= out_valid_next;
      pkt_count_reg  <= pkt_count_next;
    end
  end

  assign out_packet = out_packet_reg;
  assign out_valid  = out_valid_reg;
  assign gnt_id     = gnt_id_reg;
  assign busy       = (state_reg == GRANT) || out_valid_reg;
  assign pkt_count  = pkt_count_reg;

endmodule

// File: doc/local_port_arbiter.md
# local_port_arbiter

Round-robin scheduler that shares one router local input port among `NUM_REQ` packet sources: neuron cores, spike generators or the configuration agent. It sits between the sources and the router's local port (`local_in_packet`/`local_in_valid`/`local_in_ready`). A granted source may send a burst of up to `BURST_LEN` packets before the grant rotates. All packets pass through one registered output slot with a valid/ready handshake.

## Interface

Clocking is fixed: one clock `clk`; reset `rst` is synchronous and active-high.

Parameters:
- `NUM_REQ`, default 4: number of requesters. Legal range 2..8.
- `BURST_LEN`, default 4: maximum consecutive packets per grant. Legal range 1..16.
- `PTR_W`, default `$clog2(NUM_REQ)`: width of the requester index.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  arbitration enable.
- `req_packet`  in  `NUM_REQ*32`  packet data; requester i occupies bits [32i+31:32i].
- `req_valid`  in  `NUM_REQ`  per-requester packet valid.
- `req_ready`  out  `NUM_REQ`  per-requester accept.
- `out_packet`  out  32  to router `local_in_packet`.
- `out_valid`  out  1  to router `local_in_valid`.
- `out_ready`  in  1  from router `local_in_ready`.
- `gnt_id`  out  `PTR_W`  index of the current or last granted requester.
- `busy`  out  1  high while state is GRANT or `out_valid` is high.
- `pkt_count`  out  32  number of packets delivered on the output; wraps modulo 2^32.

## Operation

- State machine has two states, IDLE and GRANT. Internal registers: `rr_ptr` (`PTR_W` bits) and `burst_cnt` (5 bits).
- `slot_free = !out_valid || out_ready`.
- IDLE:
  - All `req_ready` are 0.
  - If `en` is high and any `req_valid` is high, pick the first requester with valid high, scanning from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - Next cycle: `gnt_id` is the picked index, `burst_cnt` is 0, state is GRANT.
- GRANT:
  - `req_ready[gnt_id] = en && slot_free`. All other `req_ready` bits are 0.
  - A transfer occurs when `req_valid[gnt_id] && req_ready[gnt_id]`. On a transfer: `out_packet <= req_packet[gnt_id]`, `out_valid <= 1`, `burst_cnt` increments.
  - Release to IDLE, setting `rr_ptr <= (gnt_id+1) mod NUM_REQ`, when any of these holds:
    - a transfer occurs with `burst_cnt == BURST_LEN-1`;
    - `req_valid[gnt_id]` is 0;
    - `en` is 0.
  - Release is evaluated every cycle and takes effect on the next edge.
- Output slot:
  - `out_valid` clears on `out_valid && out_ready` when no transfer occurs in the same cycle.
  - A simultaneous drain and fill keeps `out_valid` at 1 with the new data.
  - `pkt_count` increments on every `out_valid && out_ready`.
- `en` low:
  - Blocks new grants and new transfers.
  - The output slot still drains.
- Fairness: with all requesters continuously valid, the service order is 0,1,…,NUM_REQ-1,0,… with `BURST_LEN` packets per grant.
- The block must never drop, duplicate or reorder packets within one requester.

## Timing

- Reset values:
  - state IDLE;
  - `rr_ptr`, `gnt_id` and `burst_cnt` all 0;
  - `out_valid` 0, `out_packet` 0;
  - `pkt_count` 0, `req_ready` all 0, `busy` 0.
- Reset mid-operation discards any buffered packet. The requester sees no acceptance of that packet beyond handshakes that already completed.
- Latency, from an idle system:
  - `req_valid` rises at cycle N;
  - `req_ready` is high at N+1;
  - `out_valid` is high at N+2.
- A granted requester streams one packet per cycle while `out_ready` stays high.
- Each release costs exactly one IDLE bubble cycle.
- `out_valid && !out_ready` stalls the block:
  - `out_packet` and `out_valid` are held stable;
  - `req_ready` is 0 and `burst_cnt` holds.
- `req_ready` is combinational from state, `en`, `out_valid` and `out_ready`. It has no combinational path from `req_valid` or `req_packet`.
- `out_packet` and `out_valid` are registered outputs.

## Test plan

- Reset, then `req_valid=4'b0001` with req0 sending 0xA0000001..0xA0000006 and `out_ready=1`:
  - first `req_ready[0]` at cycle 1;
  - `out_valid` at cycle 2;
  - four packets back-to-back, one bubble, then the remaining two;
  - `pkt_count=6`.
- All four requesters continuously valid, `out_ready=1`:
  - output sources follow 0×4, 1×4, 2×4, 3×4, 0×4;
  - exactly one bubble between groups.
- Hold `out_ready=0` for 5 cycles mid-burst:
  - `out_packet` is stable;
  - `req_ready` is 0;
  - no packet is lost;
  - the burst resumes with `burst_cnt` intact.
- Requester 2 drops `req_valid` after 2 packets while requester 3 is waiting:
  - release follows;
  - `rr_ptr=3`;
  - requester 3 is granted after one IDLE cycle.
- Drive `en=0` during GRANT with a full output slot:
  - the slot drains;
  - no new `req_ready`;
  - state returns to IDLE;
  - arbitration resumes from `rr_ptr` when `en` returns to 1.
- Assert `rst` while `out_valid=1` and state is GRANT:
  - next cycle: `out_valid=0`, state IDLE, `pkt_count=0`, `rr_ptr=0`.
